systolic_seq_2by2: RTL
======================

SYSTOLIC_SEQ_2BY2 -- requirements
Module: systolic_seq_2by2

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 3: number of zero-operand cycles issued after the last operand before capture (legal 3..15).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1: one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1: job request, accepted only when ready=1.
REQ-005 The block SHALL have port abort, input, 1: cancels an in-flight job.
REQ-006 The block SHALL have ports a_mat and b_mat, input, 32 each: 2x2 operands, packed [31:24]=X11, [23:16]=X12, [15:8]=X21, [7:0]=X22.
REQ-007 The block SHALL have port ready, output, 1: high only in IDLE.
REQ-008 The block SHALL have port done, output, 1: one-cycle pulse marking c_mat valid.
REQ-009 The block SHALL have port c_mat, output, 32: result C=A*B, packed as a_mat.
REQ-010 The block SHALL have port arr_reset, output, 1: active-high clear to the 2x2 systolic array.
REQ-011 The block SHALL have ports arr_a1, arr_a2, arr_b1 and arr_b2, output, 8 each: array row/column operand feeds.
REQ-012 The block SHALL have ports arr_c1, arr_c2, arr_c3 and arr_c4, input, 8 each: array accumulators mapping to C11, C12, C21, C22.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, CLR, FEED0, FEED1, FEED2, DRAIN, CAPTURE, DONE; all outputs registered.
REQ-014 The block SHALL, on the edge where start=1 in IDLE, latch a_mat and b_mat into internal registers and go to CLR; later a_mat/b_mat changes are ignored until the next acceptance.
REQ-015 The block SHALL ignore start while ready=0; no queueing.
REQ-016 CLR SHALL last one cycle with arr_reset=1 and all operand feeds 0, then go to FEED0.
REQ-017 FEED0 SHALL drive arr_a1=A11, arr_b1=B11, arr_a2=0, arr_b2=0.
REQ-018 FEED1 SHALL drive arr_a1=A12, arr_b1=B21, arr_a2=A21, arr_b2=B12.
REQ-019 FEED2 SHALL drive arr_a1=0, arr_b1=0, arr_a2=A22, arr_b2=B22.
REQ-020 DRAIN SHALL drive all feeds 0 for exactly DRAIN_CYCLES cycles using a 4-bit counter, then go to CAPTURE.
REQ-021 CAPTURE SHALL last one cycle; on its exit edge c_mat SHALL load {arr_c1, arr_c2, arr_c3, arr_c4} and the FSM SHALL go to DONE.
REQ-022 DONE SHALL last one cycle with done=1, then go to IDLE; done SHALL be 0 in every other state.
REQ-023 With DRAIN_CYCLES=3, a start accepted at edge E0 SHALL produce done=1 in the cycle after edge E8, with ready=1 again after edge E9.
REQ-024 c_mat SHALL hold its value from one DONE until the next CAPTURE; no change on abort.
REQ-025 Arithmetic SHALL be the array's 8-bit modulo-256 accumulation; the block performs no arithmetic and reports no overflow.
REQ-026 abort=1 in CLR, FEED0-2, DRAIN or CAPTURE SHALL, on that edge, go to IDLE with one cycle of arr_reset=1, feeds 0 and no done pulse.
REQ-027 abort SHALL be ignored in IDLE and DONE.
REQ-028 abort SHALL take priority over start when both are high in the same cycle.
REQ-029 arr_reset SHALL be 0 in all states except CLR, the abort cycle and reset.

Reset
REQ-030 While reset_n=0 the block SHALL immediately be in IDLE with ready=1, done=0, c_mat=0, all arr_a*/arr_b*=0, arr_reset=1 and the drain counter 0.
REQ-031 Release of reset_n SHALL take effect synchronously; arr_reset SHALL drop on the first edge after release.
REQ-032 Reset asserted mid-job SHALL discard the job without a done pulse.

Verification
REQ-033 The bench SHALL apply A=[1 2;3 4], B=[5 6;7 8] -> done at E8, c_mat=0x13_16_2B_32 (19, 22, 43, 50).
REQ-034 The bench SHALL apply A=I, B=[9 8;7 6] -> c_mat=0x09080706, and check the feed sequence of REQ-017..019 cycle by cycle.
REQ-035 The bench SHALL apply all A and B elements = 16 -> every C element 512 mod 256 = 0, c_mat=0x00000000.
REQ-036 The bench SHALL hold start high continuously with two different jobs -> second job accepted only in IDLE after DONE, and start pulses during busy have no effect.
REQ-037 The bench SHALL assert abort during FEED1 -> one arr_reset cycle, ready=1 next cycle, no done, c_mat unchanged; the next job then computes correctly.
REQ-038 The bench SHALL assert reset_n=0 mid-DRAIN -> outputs at reset values asynchronously, no done after release.

Source files
------------

// File: rtl/systolic_seq_2by2.sv
// Sequencer for an external 2x2 output-stationary systolic array: latches A and B,
// clears the array, skews the operand feeds over three cycles, drains, then captures C.
module systolic_seq_2by2 #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a_mat,
    input  logic [31:0] b_mat,
    output logic        ready,
    output logic        done,
    output logic [31:0] c_mat,
    output logic        arr_reset,
    output logic [7:0]  arr_a1,
    output logic [7:0]  arr_a2,
    output logic [7:0]  arr_b1,
    output logic [7:0]  arr_b2,
    input  logic [7:0]  arr_c1,
    input  logic [7:0]  arr_c2,
    input  logic [7:0]  arr_c3,
    input  logic [7:0]  arr_c4
);

    // state     | meaning
    // S_IDLE    | waiting for start, ready=1
    // S_CLR     | one-cycle array clear
    // S_FEED0   | A11/B11 into PE11
    // S_FEED1   | A12/B21 into row/col 1, A21/B12 into row/col 2
    // S_FEED2   | A22/B22 into row/col 2
    // S_DRAIN   | zero feeds while the skewed products settle
    // S_CAPTURE | accumulators sampled into c_mat on exit
    // S_DONE    | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED0,
        S_FEED1,
        S_FEED2,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_mat_q, c_mat_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        arr_reset_q, arr_reset_d;
    logic [7:0]  arr_a1_q, arr_a1_d;
    logic [7:0]  arr_a2_q, arr_a2_d;
    logic [7:0]  arr_b1_q, arr_b1_d;
    logic [7:0]  arr_b2_q, arr_b2_d;
    logic        abort_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= 4'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            c_mat_q     <= 32'd0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            arr_reset_q <= 1'b1;
            arr_a1_q    <= 8'd0;
            arr_a2_q    <= 8'd0;
            arr_b1_q    <= 8'd0;
            arr_b2_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_mat_q     <= c_mat_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            arr_reset_q <= arr_reset_d;
            arr_a1_q    <= arr_a1_d;
            arr_a2_q    <= arr_a2_d;
            arr_b1_q    <= arr_b1_d;
            arr_b2_q    <= arr_b2_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        abort_hit   = 1'b0;
        case (state_q)
            S_IDLE:    if (start && !abort) state_d = S_CLR;
            S_CLR:     state_d = S_FEED0;
            S_FEED0:   state_d = S_FEED1;
            S_FEED1:   state_d = S_FEED2;
            S_FEED2: begin
                state_d     = S_DRAIN;
                drain_cnt_d = DRAIN_LOAD;
            end
            S_DRAIN: begin
                if (drain_cnt_q == 4'd0) state_d = S_CAPTURE;
                else                     drain_cnt_d = drain_cnt_q - 4'd1;
            end
            S_CAPTURE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Abort only cancels work in flight; DONE always completes its pulse.
        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d     = S_IDLE;
            drain_cnt_d = 4'd0;
            abort_hit   = 1'b1;
        end
    end

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        c_mat_d     = c_mat_q;
        ready_d     = (state_d == S_IDLE);
        done_d      = (state_d == S_DONE);
        arr_reset_d = (state_d == S_CLR) || abort_hit;
        arr_a1_d    = 8'd0;
        arr_a2_d    = 8'd0;
        arr_b1_d    = 8'd0;
        arr_b2_d    = 8'd0;
        if (state_q == S_IDLE && state_d == S_CLR) begin
            a_d = a_mat;
            b_d = b_mat;
        end
        if (state_q == S_CAPTURE && state_d == S_DONE) begin
            c_mat_d = {arr_c1, arr_c2, arr_c3, arr_c4};
        end
        case (state_d)
            S_FEED0: begin
                arr_a1_d = a_q[31:24];
                arr_b1_d = b_q[31:24];
            end
            S_FEED1: begin
                arr_a1_d = a_q[23:16];
                arr_b1_d = b_q[15:8];
                arr_a2_d = a_q[15:8];
                arr_b2_d = b_q[23:16];
            end
            S_FEED2: begin
                arr_a2_d = a_q[7:0];
                arr_b2_d = b_q[7:0];
            end
            default: ;
        endcase
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign c_mat     = c_mat_q;
    assign arr_reset = arr_reset_q;
    assign arr_a1    = arr_a1_q;
    assign arr_a2    = arr_a2_q;
    assign arr_b1    = arr_b1_q;
    assign arr_b2    = arr_b2_q;

endmodule
